// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: arbiter state encoding and client identifiers.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;
  localparam logic CLIENT_SD = 1'b0;
  localparam logic CLIENT_CPU = 1'b1;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client request/ack bundle plus RAM strobe/ready channel.
interface ram_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic c0_req, c1_req, c0_we, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic c0_ack, c1_ack, c0_err, c1_err;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_rdata;
  logic ram_sig_write, ram_sig_read, ram_is_ready;
  logic busy, grant_id;
  modport slave (
    input c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata, ram_is_ready, ram_rdata,
    output c0_ack, c1_ack, c0_err, c1_err, c0_rdata, c1_rdata, ram_address, ram_data,
    output ram_sig_write, ram_sig_read, busy, grant_id
  );
  modport master (
    output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata, ram_is_ready, ram_rdata,
    input c0_ack, c1_ack, c0_err, c1_err, c0_rdata, c1_rdata, ram_address, ram_data,
    input ram_sig_write, ram_sig_read, busy, grant_id
  );
endinterface

// File: rtl/ram_port_arbiter_rr_grant2.sv
// rr_grant2: combinational two-way grant, round-robin or client-0 priority.
module rr_grant2 import ram_arb_pkg::*; #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic id
);
  always_comb begin
    valid = req0 | req1;
    id = (req0 & req1) ? ((ROUND_ROBIN != 0) ? ~last_grant : CLIENT_SD) : (req1 ? CLIENT_CPU : CLIENT_SD);
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises SD-loader and CPU transactions onto one RAM strobe/ready channel.
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  ram_port_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  arb_state_t state;
  logic last_grant, we_q, gnt_valid, gnt_id, g_we, timed_out, done;
  logic [CW-1:0] cnt;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, rd;
  rr_grant2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_grant (
    .req0(bus.c0_req),
    .req1(bus.c1_req),
    .last_grant(last_grant),
    .valid(gnt_valid),
    .id(gnt_id)
  );
  always_comb begin
    g_we = (gnt_id == CLIENT_CPU) ? bus.c1_we : bus.c0_we;
    g_addr = (gnt_id == CLIENT_CPU) ? bus.c1_addr : bus.c0_addr;
    g_wdata = (gnt_id == CLIENT_CPU) ? bus.c1_wdata : bus.c0_wdata;
    timed_out = (TIMEOUT != 0) && (cnt == TMAX);
    done = bus.ram_is_ready || timed_out;
    rd = (bus.ram_is_ready && !we_q) ? bus.ram_rdata : '0;
  end
  // Strobes and acks default low so each is a single-cycle pulse.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= CLIENT_CPU;
      we_q <= 1'b0;
      cnt <= '0;
      bus.c0_ack <= 1'b0;
      bus.c1_ack <= 1'b0;
      bus.c0_err <= 1'b0;
      bus.c1_err <= 1'b0;
      bus.c0_rdata <= '0;
      bus.c1_rdata <= '0;
      bus.ram_address <= '0;
      bus.ram_data <= '0;
      bus.ram_sig_write <= 1'b0;
      bus.ram_sig_read <= 1'b0;
      bus.busy <= 1'b0;
      bus.grant_id <= 1'b0;
    end else begin
      bus.ram_sig_write <= 1'b0;
      bus.ram_sig_read <= 1'b0;
      bus.c0_ack <= 1'b0;
      bus.c1_ack <= 1'b0;
      bus.c0_err <= 1'b0;
      bus.c1_err <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          bus.ram_address <= g_addr;
          bus.ram_data <= g_wdata;
          bus.ram_sig_write <= g_we;
          bus.ram_sig_read <= !g_we;
          bus.grant_id <= gnt_id;
          bus.busy <= 1'b1;
          last_grant <= gnt_id;
          we_q <= g_we;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (done) begin
            if (bus.grant_id == CLIENT_CPU) begin
              bus.c1_ack <= 1'b1;
              bus.c1_err <= !bus.ram_is_ready;
              bus.c1_rdata <= rd;
            end else begin
              bus.c0_ack <= 1'b1;
              bus.c0_err <= !bus.ram_is_ready;
              bus.c0_rdata <= rd;
            end
            state <= ACK;
          end
        end
        ACK: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
